// File: rtl/nanci_pkg.sv
// Shared codes for the NANCI PE mesh: phase and neighbour-direction encodings,
// the sequencer state type, and decode helpers used by the phase controller.
package nanci_pkg;

  // Phase broadcast to every PE.
  typedef enum logic [1:0] {
    PH_IDLE    = 2'b00,
    PH_ROW     = 2'b01,
    PH_COL     = 2'b10,
    PH_COMPUTE = 2'b11
  } phase_e;

  // Neighbour select; order must match the PE neighbour ports l/r/u/d.
  typedef enum logic [1:0] {
    DIR_L = 2'b00,
    DIR_R = 2'b01,
    DIR_U = 2'b10,
    DIR_D = 2'b11
  } dir_e;

  // Sequencer states; DONE is separate from IDLE so the done cycle still counts as busy.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROW,
    ST_COL,
    ST_COMPUTE,
    ST_DONE
  } state_e;

  function automatic phase_e phase_of(state_e st);
    case (st)
      ST_ROW:     return PH_ROW;
      ST_COL:     return PH_COL;
      ST_COMPUTE: return PH_COMPUTE;
      default:    return PH_IDLE;
    endcase
  endfunction

  // Odd-even transposition: even steps pair towards r/d, odd steps towards l/u.
  function automatic dir_e sort_dir(state_e st, logic odd_step);
    case (st)
      ST_ROW:  return odd_step ? DIR_L : DIR_R;
      ST_COL:  return odd_step ? DIR_U : DIR_D;
      default: return DIR_L;
    endcase
  endfunction

endpackage

// File: rtl/nanci_phase_ctrl_if.sv
// Control bundle between the mesh host (start/abort) and the phase sequencer
// (schedule outputs that fan out to every PE).
interface nanci_phase_ctrl_if #(
  parameter int CNT_WIDTH = 8
);
  import nanci_pkg::*;

  logic                 i_start;
  logic                 i_abort;
  logic                 o_busy;
  phase_e               o_phase;
  dir_e                 o_dir;
  logic                 o_xchg_en;
  logic [CNT_WIDTH-1:0] o_step;
  logic [CNT_WIDTH-1:0] o_round;
  logic                 o_done;

  modport master (
    output i_start, i_abort,
    input  o_busy, o_phase, o_dir, o_xchg_en, o_step, o_round, o_done
  );

  modport slave (
    input  i_start, i_abort,
    output o_busy, o_phase, o_dir, o_xchg_en, o_step, o_round, o_done
  );

endinterface

// File: rtl/nanci_step_cnt.sv
// Cycle-within-step and step-within-phase counter pair for one row/column
// sort phase. Exposes next-state values so the owner can register outputs
// that line up with the counter registers, plus the end-of-phase flag.
module nanci_step_cnt #(
  parameter int SQRT_N      = 4,
  parameter int SORT_CYCLES = 1,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] step_nxt,
  output logic [CNT_WIDTH-1:0] cyc_nxt,
  output logic                 phase_last
);

  localparam logic [CNT_WIDTH-1:0] CYC_LAST  = CNT_WIDTH'(SORT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STEP_LAST = CNT_WIDTH'((SQRT_N == 0) ? 0 : SQRT_N - 1);

  logic [CNT_WIDTH-1:0] step_q;
  logic [CNT_WIDTH-1:0] cyc_q;
  logic                 cyc_last;

  // Advance cycle counter each clock; roll into the next step on the last cycle.
  always_comb begin
    cyc_last   = (cyc_q == CYC_LAST);
    phase_last = cyc_last && (step_q == STEP_LAST);
    step_nxt   = step_q;
    cyc_nxt    = cyc_q;
    if (clr) begin
      step_nxt = '0;
      cyc_nxt  = '0;
    end else if (en) begin
      if (cyc_last) begin
        cyc_nxt  = '0;
        step_nxt = phase_last ? '0 : step_q + 1'b1;
      end else begin
        cyc_nxt = cyc_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= '0;
      cyc_q  <= '0;
    end else begin
      step_q <= step_nxt;
      cyc_q  <= cyc_nxt;
    end
  end

endmodule

// File: rtl/nanci_phase_ctrl.sv
// Global shearsort sequencer for the NANCI PE mesh: ROUNDS x (row phase, column
// phase) of SQRT_N odd-even steps, then a compute phase, then a one-cycle done.
// All outputs are registered from next-state values so they change together
// with the state and never see a combinational path from start/abort.
module nanci_phase_ctrl #(
  parameter int SQRT_N         = 4,
  parameter int SORT_CYCLES    = 1,
  parameter int COMPUTE_CYCLES = 1,
  parameter int ROUNDS         = 2,
  parameter int CNT_WIDTH      = 8
) (
  input logic               clk,
  input logic               rst,
  nanci_phase_ctrl_if.slave bus
);
  import nanci_pkg::*;

  localparam logic [CNT_WIDTH-1:0] CYC_LAST   = CNT_WIDTH'(SORT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] COMP_LAST  = CNT_WIDTH'(COMPUTE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ROUND_LAST = CNT_WIDTH'(ROUNDS - 1);

  state_e               state_q;
  state_e               state_nxt;
  logic [CNT_WIDTH-1:0] round_q;
  logic [CNT_WIDTH-1:0] round_nxt;
  logic [CNT_WIDTH-1:0] comp_q;
  logic [CNT_WIDTH-1:0] comp_nxt;
  logic                 cnt_clr;
  logic                 cnt_en;
  logic [CNT_WIDTH-1:0] step_nxt;
  logic [CNT_WIDTH-1:0] cyc_nxt;
  logic                 phase_last;
  logic                 sorting_nxt;

  nanci_step_cnt #(
    .SQRT_N      (SQRT_N),
    .SORT_CYCLES (SORT_CYCLES),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_step_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr        (cnt_clr),
    .en         (cnt_en),
    .step_nxt   (step_nxt),
    .cyc_nxt    (cyc_nxt),
    .phase_last (phase_last)
  );

  // Next-state, round and compute-counter decisions; abort overrides everything outside IDLE.
  always_comb begin
    state_nxt = state_q;
    round_nxt = round_q;
    comp_nxt  = '0;
    cnt_clr   = 1'b1;
    cnt_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        round_nxt = '0;
        if (bus.i_start && !bus.i_abort)
          state_nxt = (SQRT_N == 0) ? ST_COMPUTE : ST_ROW;
      end
      ST_ROW: begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b1;
        if (phase_last) begin
          state_nxt = ST_COL;
          cnt_clr   = 1'b1;
        end
      end
      ST_COL: begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b1;
        if (phase_last) begin
          cnt_clr = 1'b1;
          if (round_q == ROUND_LAST) begin
            state_nxt = ST_COMPUTE;
          end else begin
            state_nxt = ST_ROW;
            round_nxt = round_q + 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        if (comp_q == COMP_LAST) state_nxt = ST_DONE;
        else                     comp_nxt  = comp_q + 1'b1;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        round_nxt = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        round_nxt = '0;
      end
    endcase
    if (bus.i_abort && (state_q != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      round_nxt = '0;
      comp_nxt  = '0;
      cnt_clr   = 1'b1;
      cnt_en    = 1'b0;
    end
    sorting_nxt = (state_nxt == ST_ROW) || (state_nxt == ST_COL);
  end

  // State, counters and registered schedule outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      round_q       <= '0;
      comp_q        <= '0;
      bus.o_busy    <= 1'b0;
      bus.o_phase   <= PH_IDLE;
      bus.o_dir     <= DIR_L;
      bus.o_xchg_en <= 1'b0;
      bus.o_step    <= '0;
      bus.o_round   <= '0;
      bus.o_done    <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      round_q       <= round_nxt;
      comp_q        <= comp_nxt;
      bus.o_busy    <= (state_nxt != ST_IDLE);
      bus.o_phase   <= phase_of(state_nxt);
      bus.o_dir     <= sort_dir(state_nxt, step_nxt[0]);
      bus.o_xchg_en <= sorting_nxt && (cyc_nxt == CYC_LAST);
      bus.o_step    <= sorting_nxt ? step_nxt : '0;
      bus.o_round   <= round_nxt;
      bus.o_done    <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_nanci_phase_ctrl.sv
// Bench for nanci_phase_ctrl: four instances with different shapes share one
// clock and reset. Expected per-cycle outputs go into a scoreboard queue when
// stimulus is applied and are popped against the DUT on each falling edge.
module tb_nanci_phase_ctrl;
  import nanci_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic         busy;
    logic [1:0]   phase;
    logic [1:0]   dir;
    logic         xchg;
    logic [W-1:0] step;
    logic [W-1:0] round;
    logic         done;
  } exp_t;

  typedef struct packed {
    logic start;
    logic abort;
    exp_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nanci_phase_ctrl_if #(.CNT_WIDTH(W)) ifa ();
  nanci_phase_ctrl_if #(.CNT_WIDTH(W)) ifb ();
  nanci_phase_ctrl_if #(.CNT_WIDTH(W)) ifc ();
  nanci_phase_ctrl_if #(.CNT_WIDTH(W)) ifd ();

  nanci_phase_ctrl #(.SQRT_N(2), .SORT_CYCLES(1), .COMPUTE_CYCLES(1), .ROUNDS(1), .CNT_WIDTH(W))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  nanci_phase_ctrl #(.SQRT_N(2), .SORT_CYCLES(3), .COMPUTE_CYCLES(1), .ROUNDS(1), .CNT_WIDTH(W))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  nanci_phase_ctrl #(.SQRT_N(0), .SORT_CYCLES(1), .COMPUTE_CYCLES(1), .ROUNDS(1), .CNT_WIDTH(W))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));
  nanci_phase_ctrl #(.SQRT_N(4), .SORT_CYCLES(1), .COMPUTE_CYCLES(1), .ROUNDS(2), .CNT_WIDTH(W))
    dut_d (.clk(clk), .rst(rst), .bus(ifd));

  int   n_chk    = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;
  exp_t q[$];

  function automatic exp_t mk(logic busy, logic [1:0] ph, logic [1:0] dir, logic x,
                              int step, int round, logic done);
    exp_t e;
    e.busy  = busy;
    e.phase = ph;
    e.dir   = dir;
    e.xchg  = x;
    e.step  = W'(step);
    e.round = W'(round);
    e.done  = done;
    return e;
  endfunction

  function automatic vec_t mkv(logic start, logic abort, exp_t e);
    vec_t v;
    v.start = start;
    v.abort = abort;
    v.exp   = e;
    return v;
  endfunction

  function automatic exp_t get_act(int id);
    case (id)
      0:       return mk(ifa.o_busy, ifa.o_phase, ifa.o_dir, ifa.o_xchg_en,
                         int'(ifa.o_step), int'(ifa.o_round), ifa.o_done);
      1:       return mk(ifb.o_busy, ifb.o_phase, ifb.o_dir, ifb.o_xchg_en,
                         int'(ifb.o_step), int'(ifb.o_round), ifb.o_done);
      2:       return mk(ifc.o_busy, ifc.o_phase, ifc.o_dir, ifc.o_xchg_en,
                         int'(ifc.o_step), int'(ifc.o_round), ifc.o_done);
      default: return mk(ifd.o_busy, ifd.o_phase, ifd.o_dir, ifd.o_xchg_en,
                         int'(ifd.o_step), int'(ifd.o_round), ifd.o_done);
    endcase
  endfunction

  task automatic set_in(int id, logic s, logic a);
    case (id)
      0:       begin ifa.i_start = s; ifa.i_abort = a; end
      1:       begin ifb.i_start = s; ifb.i_abort = a; end
      2:       begin ifc.i_start = s; ifc.i_abort = a; end
      default: begin ifd.i_start = s; ifd.i_abort = a; end
    endcase
  endtask

  task automatic cmp(string name, exp_t act, exp_t e);
    n_chk++;
    if (act === e) begin
      n_pass++;
    end else begin
      $display("FAIL %s @%0t: got busy=%0d phase=%0d dir=%0d xchg=%0d step=%0d round=%0d done=%0d, want busy=%0d phase=%0d dir=%0d xchg=%0d step=%0d round=%0d done=%0d",
               name, $time, act.busy, act.phase, act.dir, act.xchg, act.step, act.round, act.done,
               e.busy, e.phase, e.dir, e.xchg, e.step, e.round, e.done);
    end
  endtask

  // One clock: wait for the falling edge, pop the expected record, compare.
  task automatic step_cmp(string name, int id);
    exp_t e;
    exp_t act;
    @(negedge clk);
    act = get_act(id);
    if (act.done) done_cnt++;
    if (q.size() == 0) begin
      n_chk++;
      $display("FAIL %s @%0t: scoreboard empty, got busy=%0d phase=%0d", name, $time, act.busy, act.phase);
    end else begin
      e = q.pop_front();
      cmp(name, act, e);
    end
  endtask

  // Expected schedule of one full run, one record per clock after the start edge.
  task automatic push_run(int sn, int sc, int rounds, int cc);
    for (int r = 0; r < rounds; r++)
      for (int ph = 0; ph < 2; ph++)
        for (int s = 0; s < sn; s++)
          for (int c = 0; c < sc; c++)
            q.push_back(mk(1'b1, (ph == 1) ? 2'b10 : 2'b01,
                           (ph == 1) ? ((s % 2 == 1) ? 2'b10 : 2'b11) : ((s % 2 == 1) ? 2'b00 : 2'b01),
                           (c == sc - 1), s, r, 1'b0));
    for (int c = 0; c < cc; c++)
      q.push_back(mk(1'b1, 2'b11, 2'b00, 1'b0, 0, rounds - 1, 1'b0));
    q.push_back(mk(1'b1, 2'b00, 2'b00, 1'b0, 0, rounds - 1, 1'b1));
  endtask

  // Pulse start for one clock and drain everything queued.
  task automatic run_pulse(string name, int id);
    int n;
    n = q.size();
    set_in(id, 1'b1, 1'b0);
    step_cmp(name, id);
    set_in(id, 1'b0, 1'b0);
    for (int k = 1; k < n; k++) step_cmp(name, id);
  endtask

  vec_t va[11];

  initial begin
    for (int i = 0; i < 4; i++) set_in(i, 1'b0, 1'b0);

    // 2x2 mesh, one round: idle boundary cases, then a full run with start
    // pulses while busy and during DONE that must be ignored.
    va[0]  = mkv(1'b0, 1'b0, '0);
    va[1]  = mkv(1'b1, 1'b1, '0);
    va[2]  = mkv(1'b0, 1'b1, '0);
    va[3]  = mkv(1'b1, 1'b0, mk(1'b1, 2'b01, 2'b01, 1'b1, 0, 0, 1'b0));
    va[4]  = mkv(1'b0, 1'b0, mk(1'b1, 2'b01, 2'b00, 1'b1, 1, 0, 1'b0));
    va[5]  = mkv(1'b1, 1'b0, mk(1'b1, 2'b10, 2'b11, 1'b1, 0, 0, 1'b0));
    va[6]  = mkv(1'b0, 1'b0, mk(1'b1, 2'b10, 2'b10, 1'b1, 1, 0, 1'b0));
    va[7]  = mkv(1'b0, 1'b0, mk(1'b1, 2'b11, 2'b00, 1'b0, 0, 0, 1'b0));
    va[8]  = mkv(1'b0, 1'b0, mk(1'b1, 2'b00, 2'b00, 1'b0, 0, 0, 1'b1));
    va[9]  = mkv(1'b1, 1'b0, '0);
    va[10] = mkv(1'b0, 1'b0, '0);

    // Power-on reset: everything idle while rst is held.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) cmp("reset_state", get_act(i), '0);
    rst = 1'b0;
    q.push_back('0);
    step_cmp("after_reset", 3);

    for (int i = 0; i < 11; i++) begin
      set_in(0, va[i].start, va[i].abort);
      q.push_back(va[i].exp);
      step_cmp("vec_2x2", 0);
    end
    set_in(0, 1'b0, 1'b0);

    // Multi-cycle sort steps.
    push_run(2, 3, 1, 1);
    q.push_back('0);
    run_pulse("sort3", 1);

    // Single PE: straight to compute.
    push_run(0, 1, 1, 1);
    q.push_back('0);
    run_pulse("single_pe", 2);

    // Full 4x4, two-round run.
    push_run(4, 1, 2, 1);
    q.push_back('0);
    run_pulse("full_4x4", 3);

    // Abort in round 1 column phase step 1.
    push_run(4, 1, 2, 1);
    set_in(3, 1'b1, 1'b0);
    step_cmp("abort_pre", 3);
    set_in(3, 1'b0, 1'b0);
    for (int k = 1; k < 14; k++) step_cmp("abort_pre", 3);
    q.delete();
    done_cnt = 0;
    set_in(3, 1'b0, 1'b1);
    q.push_back('0);
    step_cmp("abort_idle", 3);
    set_in(3, 1'b0, 1'b0);
    q.push_back('0);
    step_cmp("abort_idle2", 3);
    n_chk++;
    if (done_cnt == 0) n_pass++;
    else $display("FAIL abort_no_done: got %0d done pulses, want 0", done_cnt);
    push_run(4, 1, 2, 1);
    q.push_back('0);
    run_pulse("rerun_after_abort", 3);

    // Asynchronous reset in the middle of the row phase.
    push_run(4, 1, 2, 1);
    set_in(3, 1'b1, 1'b0);
    step_cmp("pre_rst", 3);
    set_in(3, 1'b0, 1'b0);
    step_cmp("pre_rst", 3);
    step_cmp("pre_rst", 3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 cmp("rst_async", get_act(3), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("rst_held", get_act(3), '0);
    rst = 1'b0;
    q.delete();
    q.push_back('0);
    step_cmp("rst_release", 3);

    // Start held high: three back-to-back runs.
    done_cnt = 0;
    set_in(3, 1'b1, 1'b0);
    for (int run = 0; run < 3; run++) begin
      push_run(4, 1, 2, 1);
      q.push_back('0);
      for (int k = 0; k < 19; k++) begin
        step_cmp("held_start", 3);
        if (run == 2 && k == 0) set_in(3, 1'b0, 1'b0);
      end
    end
    q.push_back('0);
    step_cmp("held_end_idle", 3);
    n_chk++;
    if (done_cnt == 3) n_pass++;
    else $display("FAIL held_done_count: got %0d done pulses, want 3", done_cnt);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
